// File: rtl/pwm_meter_pkg.sv
// Shared types and constants for the PWM duty meter.
package pwm_meter_pkg;

  // Default window exponent: 2^6 = 64 clocks, one PWM period.
  localparam int unsigned WindowLog2Default = 6;
  localparam int unsigned DutyWidthDefault  = WindowLog2Default + 1;

  typedef enum logic [1:0] {
    StIdle,
    StAlign,
    StMeasure
  } meter_state_e;

  // Duty needs one extra bit so a constant-high window (2^W) fits.
  function automatic int unsigned duty_width(input int unsigned window_log2);
    return window_log2 + 1;
  endfunction

endpackage

// File: rtl/pwm_edge_det.sv
// Rising-edge detector: registers the input and flags low-to-high transitions.
module pwm_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic p_q;

  // Registered copy of the input for edge comparison
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= 1'b0;
    end else begin
      p_q <= sig;
    end
  end

  assign rise = sig & ~p_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// PWM duty meter: aligns a 2^WINDOW_LOG2 window to the PWM rising edge, counts
// high cycles per window and reports the duty with a one-cycle valid strobe.
// Optional: define PWM_DUTY_AVG_EN to report the average of the last 4 results.
module pwm_duty_meter
  import pwm_meter_pkg::*;
#(
  parameter int unsigned WINDOW_LOG2 = WindowLog2Default,
  parameter int unsigned ENV_THRESH  = 1
) (
  input  logic                   sysclk,
  input  logic                   rst_n,
  input  logic                   Pulse_In,
  input  logic                   Enable_SW_3,
  output logic [WINDOW_LOG2:0]   Duty_Out,
  output logic                   Duty_Valid,
  output logic                   Env_On
);

  localparam int unsigned DW = duty_width(WINDOW_LOG2);
  localparam logic [WINDOW_LOG2-1:0] WinLast = '1;

  meter_state_e           state_q, state_d;
  logic [WINDOW_LOG2-1:0] win_q, win_d;
  logic [DW-1:0]          high_q, high_d;
  logic [DW-1:0]          duty_q, duty_d;
  logic                   valid_q, valid_d;
  logic                   env_q, env_d;

  logic          rise;
  logic [DW-1:0] raw;
  logic [DW-1:0] raw_res;
  logic [DW-1:0] result;
  logic          env_hit;

  pwm_edge_det u_edge (
    .clk   (sysclk),
    .rst_n (rst_n),
    .sig   (Pulse_In),
    .rise  (rise)
  );

  // Window result includes the last cycle's sample; an ALIGN timeout reports 0.
  assign raw     = high_q + {{(DW-1){1'b0}}, Pulse_In};
  assign raw_res = (state_q == StMeasure) ? raw : '0;
  assign env_hit = (32'(raw_res) >= ENV_THRESH);

`ifdef PWM_DUTY_AVG_EN
  logic [DW-1:0] hist_q [3];
  logic [DW+1:0] hist_sum;

  assign hist_sum = {2'b00, raw_res} + {2'b00, hist_q[0]} + {2'b00, hist_q[1]} +
                    {2'b00, hist_q[2]};
  assign result   = hist_sum[DW+1:2];

  // History of the previous three raw results; cleared whenever IDLE is entered
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q[0] <= '0;
      hist_q[1] <= '0;
      hist_q[2] <= '0;
    end else if (state_d == StIdle) begin
      hist_q[0] <= '0;
      hist_q[1] <= '0;
      hist_q[2] <= '0;
    end else if (valid_d) begin
      hist_q[0] <= raw_res;
      hist_q[1] <= hist_q[0];
      hist_q[2] <= hist_q[1];
    end
  end
`else
  assign result = raw_res;
`endif

  // Next-state and counter/output update logic
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    high_d  = high_q;
    duty_d  = duty_q;
    valid_d = 1'b0;
    env_d   = env_q;

    unique case (state_q)
      StIdle: begin
        win_d  = '0;
        high_d = '0;
        duty_d = '0;
        env_d  = 1'b0;
        // An edge coinciding with enable is not seen here; ALIGN waits for the next one.
        if (Enable_SW_3) begin
          state_d = StAlign;
        end
      end

      StAlign: begin
        if (!Enable_SW_3) begin
          state_d = StIdle;
          win_d   = '0;
          high_d  = '0;
          duty_d  = '0;
          env_d   = 1'b0;
        end else if (rise) begin
          // Edge cycle is window cycle 0 and is already high.
          state_d = StMeasure;
          high_d  = {{(DW-1){1'b0}}, 1'b1};
          win_d   = WINDOW_LOG2'(1);
        end else begin
          win_d = win_q + WINDOW_LOG2'(1);
          if (win_q == WinLast) begin
            valid_d = 1'b1;
            duty_d  = result;
            env_d   = 1'b0;
          end
        end
      end

      StMeasure: begin
        if (!Enable_SW_3) begin
          state_d = StIdle;
          win_d   = '0;
          high_d  = '0;
          duty_d  = '0;
          env_d   = 1'b0;
        end else if (win_q == WinLast) begin
          valid_d = 1'b1;
          duty_d  = result;
          env_d   = env_hit;
          high_d  = '0;
          win_d   = '0;
          // An all-low window means the burst ended; re-lock on the next edge.
          if (raw == '0) begin
            state_d = StAlign;
          end
        end else begin
          high_d = raw;
          win_d  = win_q + WINDOW_LOG2'(1);
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      win_q   <= '0;
      high_q  <= '0;
      duty_q  <= '0;
      valid_q <= 1'b0;
      env_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      high_q  <= high_d;
      duty_q  <= duty_d;
      valid_q <= valid_d;
      env_q   <= env_d;
    end
  end

  assign Duty_Out   = duty_q;
  assign Duty_Valid = valid_q;
  assign Env_On     = env_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed self-checking bench for pwm_duty_meter (64-clock window).
module tb_pwm_duty_meter;
  import pwm_meter_pkg::*;

  logic       sysclk;
  logic       rst_n;
  logic       Pulse_In;
  logic       Enable_SW_3;
  logic [6:0] Duty_Out;
  logic       Duty_Valid;
  logic       Env_On;

  int total = 0;
  int bad   = 0;

  // Generator model: Pulse_In high for phase < duty within each 64-clock period.
  int phase     = 0;
  int duty      = 0;
  int duty_next = 0;

`ifdef PWM_DUTY_AVG_EN
  int h0 = 0;
  int h1 = 0;
  int h2 = 0;
`endif

  pwm_duty_meter #(
    .WINDOW_LOG2 (6),
    .ENV_THRESH  (1)
  ) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .Pulse_In    (Pulse_In),
    .Enable_SW_3 (Enable_SW_3),
    .Duty_Out    (Duty_Out),
    .Duty_Valid  (Duty_Valid),
    .Env_On      (Env_On)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic hist_clear();
`ifdef PWM_DUTY_AVG_EN
    h0 = 0;
    h1 = 0;
    h2 = 0;
`endif
  endtask

  // Expected reported duty for a given raw window result.
  function automatic int model(input int raw);
`ifdef PWM_DUTY_AVG_EN
    int s;
    s  = raw + h0 + h1 + h2;
    h2 = h1;
    h1 = h0;
    h0 = raw;
    return s / 4;
`else
    return raw;
`endif
  endfunction

  task automatic set_pwm(input int d);
    duty      = d;
    duty_next = d;
    phase     = 0;
    Pulse_In  = (phase < duty);
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge sysclk);
    #1;
    phase = (phase + 1) % 64;
    if (phase == 0) duty = duty_next;
    Pulse_In = (phase < duty);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 200) begin
      cyc();
      n++;
      if (Duty_Valid === 1'b1) break;
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    Enable_SW_3 = 1'b0;
    set_pwm(0);
    hist_clear();
    repeat (2) @(posedge sysclk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int seen;

    // Reset state
    do_reset();
    check("rst_duty", 32'(Duty_Out), 32'd0);
    check("rst_valid", 32'(Duty_Valid), 32'd0);
    check("rst_env", 32'(Env_On), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(StIdle));
    check("rst_pq", 32'(dut.u_edge.p_q), 32'd0);

    // Duty 20 aligned to the first rising edge
    Enable_SW_3 = 1'b1;
    cyc();
    set_pwm(20);
    wait_valid(n);
    check("d20_lat", n, 64);
    check("d20_val1", 32'(Duty_Out), model(20));
    check("d20_env1", 32'(Env_On), 32'd1);
    wait_valid(n);
    check("d20_spacing", n, 64);
    check("d20_val2", 32'(Duty_Out), model(20));
    cyc();
    check("d20_strobe_1cyc", 32'(Duty_Valid), 32'd0);
    check("d20_hold", 32'(Duty_Out), model(20));

    // Constant low: ALIGN timeouts report 0
    do_reset();
    Enable_SW_3 = 1'b1;
    wait_valid(n);
    check("zero_lat", n, 65);
    check("zero_val", 32'(Duty_Out), model(0));
    check("zero_env", 32'(Env_On), 32'd0);
    wait_valid(n);
    check("zero_spacing", n, 64);
    check("zero_state", 32'(dut.state_q), 32'(StAlign));

    // Constant high starting on the first ALIGN cycle
    do_reset();
    Enable_SW_3 = 1'b1;
    cyc();
    set_pwm(64);
    wait_valid(n);
    check("one_lat", n, 64);
    check("one_val1", 32'(Duty_Out), model(64));
    check("one_env", 32'(Env_On), 32'd1);
    wait_valid(n);
    check("one_spacing", n, 64);
    check("one_val2", 32'(Duty_Out), model(64));

    // Edge in the same cycle as enable is ignored; no later edge means timeouts
    do_reset();
    Enable_SW_3 = 1'b1;
    set_pwm(64);
    wait_valid(n);
    check("same_lat", n, 65);
    check("same_val", 32'(Duty_Out), model(0));
    check("same_env", 32'(Env_On), 32'd0);
    check("same_state", 32'(dut.state_q), 32'(StAlign));

    // Duty 30, enable dropped at window cycle 40, then re-enabled
    do_reset();
    Enable_SW_3 = 1'b1;
    cyc();
    set_pwm(30);
    wait_valid(n);
    check("d30_val1", 32'(Duty_Out), model(30));
    seen = 0;
    repeat (40) begin
      cyc();
      if (Duty_Valid === 1'b1) seen++;
    end
    Enable_SW_3 = 1'b0;
    hist_clear();
    cyc();
    check("drop_state", 32'(dut.state_q), 32'(StIdle));
    check("drop_duty", 32'(Duty_Out), 32'd0);
    check("drop_env", 32'(Env_On), 32'd0);
    repeat (79) begin
      cyc();
      if (Duty_Valid === 1'b1) seen++;
    end
    check("drop_no_valid", seen, 0);
    Enable_SW_3 = 1'b1;
    wait_valid(n);
    check("reen_lat", n, 72);
    check("reen_val", 32'(Duty_Out), model(30));
    check("reen_env", 32'(Env_On), 32'd1);
    wait_valid(n);
    check("reen_spacing", n, 64);
    check("reen_val2", 32'(Duty_Out), model(30));

    // Successive window duties 8, 16, 24, 32
    do_reset();
    Enable_SW_3 = 1'b1;
    cyc();
    set_pwm(8);
    duty_next = 16;
    wait_valid(n);
    check("seq_w1", 32'(Duty_Out), model(8));
    duty_next = 24;
    wait_valid(n);
    check("seq_w2", 32'(Duty_Out), model(16));
    duty_next = 32;
    wait_valid(n);
    check("seq_w3", 32'(Duty_Out), model(24));
    wait_valid(n);
    check("seq_w4", 32'(Duty_Out), model(32));
    check("seq_spacing", n, 64);
    check("seq_env", 32'(Env_On), 32'd1);

    // Asynchronous reset at window cycle 25
    do_reset();
    Enable_SW_3 = 1'b1;
    cyc();
    set_pwm(20);
    wait_valid(n);
    check("mid_pre", 32'(Duty_Out), model(20));
    repeat (25) cyc();
    rst_n = 1'b0;
    #1;
    check("mid_duty", 32'(Duty_Out), 32'd0);
    check("mid_valid", 32'(Duty_Valid), 32'd0);
    check("mid_env", 32'(Env_On), 32'd0);
    check("mid_state", 32'(dut.state_q), 32'(StIdle));
    repeat (2) @(posedge sysclk);
    #1;
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
